booth_mul_ctrl: RTL and testbench

Sequential signed (two's-complement) radix-2 Booth multiplier controller for the ALU datapath. It takes two WIDTH-bit operands over a valid/ready handshake and runs one Booth iteration per clock. Each iteration either adds the multiplicand, adds its conditional complement plus carry-in (subtract), or skips, then shifts. It returns the 2·WIDTH-bit product over a second valid/ready handshake. It is the multi-cycle sequencer that shares one WIDTH+1-bit adder and one conditional inverter across all iterations.

---
 rtl/booth_pkg.sv | 36 +++
 rtl/booth_mul_ctrl_cond_inv.sv | 19 +
 rtl/booth_mul_ctrl.sv | 121 ++++++++++++
 tb/tb_booth_mul_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// booth_pkg
// Shared definitions for the radix-2 Booth multiplier controller:
//   - state_t    : controller state encoding (IDLE, RUN, DONE)
//   - booth_op_t : decode of the Booth pair {Q[0], q_m1} (NOP, ADD, SUB)
//   - DEFAULT_WIDTH : default operand width
//   - booth_decode  : maps the Booth pair onto an operation
package booth_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    NOP = 2'd0,
    ADD = 2'd1,
    SUB = 2'd2
  } booth_op_t;

  // 01 -> add M, 10 -> subtract M, 00/11 -> leave the accumulator alone.
  function automatic booth_op_t booth_decode(input logic q0, input logic q_m1);
    booth_op_t op;
    // NOTE: op gets a value on every path (default arm) so no latch is implied
    // when this decode is used from combinational logic.
    case ({q0, q_m1})
      2'b01:   op = ADD;
      2'b10:   op = SUB;
      default: op = NOP;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/booth_mul_ctrl_cond_inv.sv
// cond_inv
// Conditional inverter shared by every Booth iteration. Together with the
// adder carry-in it turns "add M" into "subtract M".
// Ports:
//   inv   : 1 -> y = ~value, 0 -> y = value
//   value : WIDTH-bit input word
//   y     : WIDTH-bit output word
module cond_inv #(
  parameter int WIDTH = 9
) (
  input  logic             inv,
  input  logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] y
);

  // XOR with a replicated control bit is the inverter/pass-through in one gate.
  assign y = value ^ {WIDTH{inv}};

endmodule

// File: rtl/booth_mul_ctrl.sv
// booth_mul_ctrl
// Sequential signed radix-2 Booth multiplier. Operands are accepted over a
// valid/ready handshake, one Booth iteration runs per clock on a shared
// WIDTH+1-bit adder and conditional inverter, and the 2*WIDTH-bit product is
// returned over a second valid/ready handshake.
// Ports:
//   clk          : rising-edge clock
//   rst          : synchronous active-high reset
//   start_valid  : a/b valid
//   start_ready  : operands can be accepted (IDLE only)
//   a, b         : signed multiplicand / multiplier (WIDTH bits)
//   result_valid : product valid (DONE only)
//   result_ready : consumer accepts product
//   product      : signed product a*b (2*WIDTH bits), registered
//   busy         : RUN or DONE
module booth_mul_ctrl
  import booth_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_valid,
  output logic               start_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               result_valid,
  input  logic               result_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t         state;
  logic [WIDTH:0] m;      // sign-extended multiplicand
  logic [WIDTH:0] acc;    // upper half of the shift register
  logic [WIDTH-1:0] q;    // multiplier / lower half of the product
  logic           q_m1;
  logic [CW-1:0]  cnt;

  // Iteration datapath: decode, conditional invert, add, arithmetic shift.
  booth_op_t      op;
  logic           inv;
  logic [WIDTH:0] m_sel;
  logic [WIDTH:0] addend;
  logic [WIDTH:0] sum;
  logic [WIDTH:0] acc_n;
  logic [WIDTH-1:0] q_n;
  logic           q_m1_n;

  assign op  = booth_decode(q[0], q_m1);
  assign inv = (op == SUB);

  cond_inv #(.WIDTH(WIDTH + 1)) u_cond_inv (
    .inv   (inv),
    .value (m),
    .y     (m_sel)
  );

  // NOP adds zero with no carry-in, so the accumulator passes through.
  // The carry-out of the WIDTH+1-bit sum is dropped; the extra bit already
  // covers the a = -2^(WIDTH-1) case.
  assign addend = (op == NOP) ? '0 : m_sel;
  assign sum    = acc + addend + {{WIDTH{1'b0}}, inv};

  // Arithmetic shift right of {sum, q, q_m1}, replicating the sign bit.
  assign acc_n  = {sum[WIDTH], sum[WIDTH:1]};
  assign q_n    = {sum[0], q[WIDTH-1:1]};
  assign q_m1_n = q[0];

  // Handshake/status outputs depend on registered state only.
  assign start_ready  = (state == IDLE);
  assign result_valid = (state == DONE);
  assign busy         = (state == RUN) || (state == DONE);

  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values of the others, matching the hardware.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the whole datapath is cleared on reset, not just the FSM, so a
      // reset mid-operation can never leave stale partial results behind.
      state   <= IDLE;
      m       <= '0;
      acc     <= '0;
      q       <= '0;
      q_m1    <= 1'b0;
      cnt     <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            m     <= {a[WIDTH-1], a};
            acc   <= '0;
            q     <= b;
            q_m1  <= 1'b0;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          acc  <= acc_n;
          q    <= q_n;
          q_m1 <= q_m1_n;
          cnt  <= cnt + CW'(1);
          if (cnt == LAST) begin
            product <= {acc_n[WIDTH-1:0], q_n};
            state   <= DONE;
          end
        end
        DONE: begin
          if (result_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mul_ctrl.sv
// tb_booth_mul_ctrl
// Self-checking bench for booth_mul_ctrl (WIDTH = 8): directed corner
// operands, randomized operands, backpressure, mid-run reset and
// back-to-back issue, all compared against plain signed multiplication.
module tb_booth_mul_ctrl;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           start_valid;
  logic           start_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           result_valid;
  logic           result_ready;
  logic [2*W-1:0] product;
  logic           busy;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  booth_mul_ctrl #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .a            (a),
    .b            (b),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .product      (product),
    .busy         (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference: exact signed product, truncated to 2*W bits.
  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
    int sx, sy;
    sx = $signed(x);
    sy = $signed(y);
    return 16'(sx * sy);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for result_valid; returns the number of edges waited.
  // Also reports whether busy stayed high, start_ready stayed low and
  // product held its old value while waiting.
  task automatic wait_valid(output int lat, output bit run_ok);
    logic [2*W-1:0] held;
    held   = product;
    lat    = 0;
    run_ok = 1'b1;
    while (!result_valid && lat < 40) begin
      if (!busy || start_ready || product !== held) run_ok = 1'b0;
      tick();
      lat++;
    end
    if (lat >= 40) check("result_valid timeout", 32'(lat), 32'(W));
  endtask

  // One complete transaction with result_ready asserted immediately.
  task automatic run_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [2*W-1:0] exp);
    int lat;
    bit run_ok;
    check({tag, " start_ready"}, 32'(start_ready), 32'd1);
    a = x; b = y; start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    a = W'($urandom); b = W'($urandom);   // must be ignored from here on
    wait_valid(lat, run_ok);
    check({tag, " latency"}, 32'(lat), 32'(W));
    check({tag, " run status"}, 32'(run_ok), 32'd1);
    check({tag, " product"}, 32'(product), 32'(exp));
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    check({tag, " back to idle"}, {30'd0, start_ready, result_valid}, 32'b10);
  endtask

  typedef struct {
    logic [W-1:0]   x;
    logic [W-1:0]   y;
    logic [2*W-1:0] p;
  } vec_t;

  vec_t dir[7] = '{
    '{8'd5,    8'd3,    16'h000F},
    '{8'd7,    8'hFD,   16'hFFEB},
    '{8'hFF,   8'hFF,   16'h0001},
    '{8'd0,    8'h80,   16'h0000},
    '{8'h80,   8'h80,   16'h4000},
    '{8'h80,   8'h7F,   16'hC080},
    '{8'h7F,   8'h7F,   16'h3F01}
  };

  initial begin
    int lat;
    bit run_ok;
    bit stable;
    int t_prev;
    logic [W-1:0]   x, y;
    logic [2*W-1:0] held;

    rst = 1'b1; start_valid = 1'b0; result_ready = 1'b0; a = '0; b = '0;
    tick(); tick();
    check("reset outputs", {28'd0, start_ready, result_valid, busy, 1'b0}, 32'b1000);
    check("reset product", 32'(product), 32'd0);
    rst = 1'b0;
    tick();

    // Directed operands from the corner list.
    foreach (dir[i]) begin
      check($sformatf("model dir%0d", i), 32'(ref_mul(dir[i].x, dir[i].y)), 32'(dir[i].p));
      run_op($sformatf("dir%0d", i), dir[i].x, dir[i].y, dir[i].p);
    end

    // Randomized operands.
    for (int i = 0; i < 20; i++) begin
      x = W'($urandom); y = W'($urandom);
      run_op($sformatf("rnd%0d", i), x, y, ref_mul(x, y));
    end

    // Backpressure: hold DONE for 5 cycles while offering new operands.
    a = 8'd100; b = 8'hC3; start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    wait_valid(lat, run_ok);
    check("bp product", 32'(product), 32'(ref_mul(8'd100, 8'hC3)));
    held = product;
    stable = 1'b1;
    start_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      a = W'($urandom); b = W'($urandom);
      tick();
      if (product !== held || !result_valid || start_ready || !busy) stable = 1'b0;
    end
    check("bp hold stable", 32'(stable), 32'd1);
    // Handshake edge: operands present here must not be captured.
    a = 8'h11; b = 8'h22; result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    check("bp idle after handshake", {30'd0, start_ready, busy}, 32'b10);
    x = 8'hE5; y = 8'h37;
    a = x; b = y;
    tick();                               // accepted here, from IDLE
    start_valid = 1'b0;
    check("bp accepted from idle", 32'(busy), 32'd1);
    wait_valid(lat, run_ok);
    check("bp next product", 32'(product), 32'(ref_mul(x, y)));
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;

    // Reset during the 4th iteration.
    a = 8'h5A; b = 8'hA5; start_valid = 1'b1;
    tick();                               // E0
    start_valid = 1'b0;
    tick(); tick(); tick();               // E1..E3
    rst = 1'b1;
    tick();                               // reset takes effect on E4
    check("midrun reset outputs", {28'd0, start_ready, result_valid, busy, 1'b0}, 32'b1000);
    check("midrun reset product", 32'(product), 32'd0);
    rst = 1'b0;
    stable = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (result_valid || busy) stable = 1'b0;
    end
    check("no valid after reset", 32'(stable), 32'd1);
    run_op("after reset 6x-7", 8'd6, 8'hF9, 16'hFFD6);

    // Back-to-back issue with result_ready tied high.
    result_ready = 1'b1;
    start_valid  = 1'b1;
    t_prev = 0;
    for (int k = 0; k < 6; k++) begin
      x = W'($urandom); y = W'($urandom);
      a = x; b = y;
      lat = 0;
      while (!start_ready && lat < 20) begin
        tick();
        lat++;
      end
      tick();                             // acceptance edge
      if (k > 0) check($sformatf("b2b interval %0d", k), 32'(cyc - t_prev), 32'(W + 2));
      t_prev = cyc;
      wait_valid(lat, run_ok);
      check($sformatf("b2b product %0d", k), 32'(product), 32'(ref_mul(x, y)));
    end
    start_valid  = 1'b0;
    tick();
    result_ready = 1'b0;
    tick();
    check("b2b final idle", {30'd0, start_ready, busy}, 32'b10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
